// File: rtl/fp_alu_seq.sv
// Sequential valid/ready front end for a combinational single-precision FP ALU.
// Operands are registered and held for SETTLE_CYCLES edges before capture.
module fp_alu_seq #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [2:0]  in_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_exception,
    input  logic        alu_overflow,
    input  logic        alu_underflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_exception,
    output logic        out_overflow,
    output logic        out_underflow,
    output logic        out_illegal,
    output logic        sticky_exception,
    output logic        sticky_overflow,
    output logic        sticky_underflow,
    input  logic        clr_sticky
);

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       capture;

    assign in_ready = (state == IDLE) && rst_n;
    assign capture  = (state == SETTLE) && (cnt == 4'd0);

    // NOTE: every register, including the datapath ones, is cleared by the
    // synchronous reset so a reset mid-operation leaves nothing half-captured.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= 4'd0;
            alu_a            <= 32'd0;
            alu_b            <= 32'd0;
            alu_op           <= 3'd0;
            out_valid        <= 1'b0;
            out_result       <= 32'd0;
            out_exception    <= 1'b0;
            out_overflow     <= 1'b0;
            out_underflow    <= 1'b0;
            out_illegal      <= 1'b0;
            sticky_exception <= 1'b0;
            sticky_overflow  <= 1'b0;
            sticky_underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!in_op[2]) begin
                            alu_a  <= in_a;
                            alu_b  <= in_b;
                            alu_op <= in_op;
                            cnt    <= CNT_LOAD;
                            state  <= SETTLE;
                        end else begin
                            // Illegal opcodes never reach the ALU; answer at once.
                            out_result    <= 32'd0;
                            out_exception <= 1'b0;
                            out_overflow  <= 1'b0;
                            out_underflow <= 1'b0;
                            out_illegal   <= 1'b1;
                            out_valid     <= 1'b1;
                            state         <= DONE;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        out_result    <= alu_result;
                        out_exception <= alu_exception;
                        out_overflow  <= alu_overflow;
                        out_underflow <= alu_underflow;
                        out_illegal   <= 1'b0;
                        out_valid     <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A clear coinciding with a capture still keeps the new event.
            if (capture) begin
                sticky_exception <= (sticky_exception && !clr_sticky) || alu_exception;
                sticky_overflow  <= (sticky_overflow  && !clr_sticky) || alu_overflow;
                sticky_underflow <= (sticky_underflow && !clr_sticky) || alu_underflow;
            end else if (clr_sticky) begin
                sticky_exception <= 1'b0;
                sticky_overflow  <= 1'b0;
                sticky_underflow <= 1'b0;
            end
        end
    end

endmodule
